lsu_mem_arbiter: RTL and testbench

Shares one single-port synchronous SRAM bank among `N_REQ` LSUs. Each LSU issues fire-and-forget read requests (`ren` + address) and write requests (`wen` + address + store data) with no back-pressure. The arbiter buffers each LSU's requests in a small per-requester queue and grants one bank access per cycle in round-robin order. It returns read data to the owning LSU as a `{valid, data}` pair in the same format the LSU already consumes on its CBG bus.

---
 rtl/lsu_mem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: shares one single-port synchronous SRAM bank among N_REQ LSUs.
// Each LSU gets a small request queue, one bank access is granted per cycle in
// round-robin order, and read data is routed back to the owning LSU.
module lsu_mem_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned A_W     = 10,
  parameter int unsigned D_W     = 32,
  parameter int unsigned Q_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     rd_req_i,
  input  logic [N_REQ*A_W-1:0] rd_addr_i,
  input  logic [N_REQ-1:0]     wr_req_i,
  input  logic [N_REQ*A_W-1:0] wr_addr_i,
  input  logic [N_REQ*D_W-1:0] wr_data_i,
  output logic [N_REQ-1:0]     rsp_valid_o,
  output logic [N_REQ*D_W-1:0] rsp_data_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [A_W-1:0]       mem_addr_o,
  output logic [D_W-1:0]       mem_wdata_o,
  input  logic [D_W-1:0]       mem_rdata_i,
  output logic [N_REQ-1:0]     q_full_o,
  output logic [N_REQ-1:0]     ovf_o,
  output logic                 busy_o
);

  localparam int unsigned PW = $clog2(Q_DEPTH);
  localparam int unsigned CW = $clog2(Q_DEPTH + 1);
  localparam int unsigned FW = CW + 1;
  localparam int unsigned IW = $clog2(N_REQ);

  // Per-requester circular queues of {we, addr, data}
  logic           q_we_q   [N_REQ][Q_DEPTH];
  logic [A_W-1:0] q_addr_q [N_REQ][Q_DEPTH];
  logic [D_W-1:0] q_data_q [N_REQ][Q_DEPTH];
  logic [PW-1:0]  rd_ptr_q [N_REQ];
  logic [PW-1:0]  wr_ptr_q [N_REQ];
  logic [PW-1:0]  wr_slot  [N_REQ];
  logic [CW-1:0]  cnt_q    [N_REQ];
  logic [CW-1:0]  cnt_d    [N_REQ];

  logic [IW-1:0]    ptr_q, ptr_d;
  logic             gnt_vld;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_we;
  logic [A_W-1:0]   gnt_addr;
  logic [D_W-1:0]   gnt_data;
  logic [N_REQ-1:0] pop, push_rd, push_wr, drop;

  logic             mem_en_q, mem_we_q;
  logic [A_W-1:0]   mem_addr_q;
  logic [D_W-1:0]   mem_wdata_q;
  logic             t1_vld_q, t2_vld_q;
  logic [IW-1:0]    t1_own_q, t2_own_q;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [N_REQ*D_W-1:0] rsp_data_q, rsp_data_d;
  logic [N_REQ-1:0] ovf_q;

  // Round-robin scan from ptr_q; first non-empty queue wins
  always_comb begin
    int unsigned j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = 32'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!gnt_vld && cnt_q[IW'(j)] != '0) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(j);
      end
    end
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
  end

  assign gnt_we   = q_we_q[gnt_idx][rd_ptr_q[gnt_idx]];
  assign gnt_addr = q_addr_q[gnt_idx][rd_ptr_q[gnt_idx]];
  assign gnt_data = q_data_q[gnt_idx][rd_ptr_q[gnt_idx]];

  // Push accounting: read before write, slots freed by this cycle's pop are reusable
  always_comb begin
    logic [FW-1:0] free;
    free    = '0;
    pop     = '0;
    push_rd = '0;
    push_wr = '0;
    drop    = '0;
    cnt_d   = cnt_q;
    wr_slot = wr_ptr_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pop[i]     = gnt_vld && (gnt_idx == IW'(i));
      free       = FW'(Q_DEPTH) - FW'(cnt_q[i]) + FW'(pop[i]);
      push_rd[i] = rd_req_i[i] && (free != '0);
      push_wr[i] = wr_req_i[i] && (free > FW'(rd_req_i[i]));
      drop[i]    = (rd_req_i[i] && !push_rd[i]) || (wr_req_i[i] && !push_wr[i]);
      cnt_d[i]   = cnt_q[i] - CW'(pop[i]) + CW'(push_rd[i]) + CW'(push_wr[i]);
      wr_slot[i] = wr_ptr_q[i] + PW'(push_rd[i]);
    end
  end

  // Queue storage and pointers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        for (int unsigned s = 0; s < Q_DEPTH; s++) begin
          q_we_q[i][s]   <= 1'b0;
          q_addr_q[i][s] <= '0;
          q_data_q[i][s] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cnt_q[i]    <= cnt_d[i];
        wr_ptr_q[i] <= wr_ptr_q[i] + PW'(push_rd[i]) + PW'(push_wr[i]);
        if (pop[i]) rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        if (push_rd[i]) begin
          q_we_q[i][wr_ptr_q[i]]   <= 1'b0;
          q_addr_q[i][wr_ptr_q[i]] <= rd_addr_i[i*A_W +: A_W];
          q_data_q[i][wr_ptr_q[i]] <= '0;
        end
        if (push_wr[i]) begin
          q_we_q[i][wr_slot[i]]   <= 1'b1;
          q_addr_q[i][wr_slot[i]] <= wr_addr_i[i*A_W +: A_W];
          q_data_q[i][wr_slot[i]] <= wr_data_i[i*D_W +: D_W];
        end
      end
    end
  end

  // Arbiter pointer, bank drive registers, read tag pipe and sticky overflow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      t1_vld_q    <= 1'b0;
      t1_own_q    <= '0;
      t2_vld_q    <= 1'b0;
      t2_own_q    <= '0;
      ovf_q       <= '0;
    end else begin
      ptr_q    <= ptr_d;
      mem_en_q <= gnt_vld;
      mem_we_q <= gnt_vld && gnt_we;
      if (gnt_vld) begin
        mem_addr_q  <= gnt_addr;
        mem_wdata_q <= gnt_data;
      end
      t1_vld_q <= gnt_vld && !gnt_we;
      t1_own_q <= gnt_idx;
      t2_vld_q <= t1_vld_q;
      t2_own_q <= t1_own_q;
      ovf_q    <= ovf_q | drop;
    end
  end

  // Route bank read data to the owner when its tag reaches stage 2
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (t2_vld_q && t2_own_q == IW'(i)) begin
        rsp_valid_d[i]             = 1'b1;
        rsp_data_d[i*D_W +: D_W]   = mem_rdata_i;
      end
    end
  end

  // Response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Status flags from registered state
  always_comb begin
    q_full_o = '0;
    busy_o   = t1_vld_q || t2_vld_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      q_full_o[i] = (cnt_q[i] == CW'(Q_DEPTH));
      if (cnt_q[i] != '0) busy_o = 1'b1;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Testbench for lsu_mem_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model with its own memory image.
module tb_lsu_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int QD = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    rd_req, wr_req;
  logic [N*AW-1:0] rd_addr, wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_data;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
  logic [N-1:0]    q_full, ovf;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  lsu_mem_arbiter #(.N_REQ(N), .A_W(AW), .D_W(DW), .Q_DEPTH(QD)) dut (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .q_full_o(q_full), .ovf_o(ovf), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Single-port synchronous SRAM bank
  logic [DW-1:0] sram [1<<AW];
  always @(posedge clk) begin
    if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
    else if (mem_en) mem_rdata <= sram[mem_addr];
  end

  // Reference model state
  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;
  ent_t          mq [N][$];
  logic [DW-1:0] ref_mem [1<<AW];
  int            mptr;
  logic [N-1:0]  movf;
  bit            e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [N-1:0]  e_rsp_valid;
  logic [N*DW-1:0] e_rsp_data;
  bit            p1v, p2v;
  int            p1o, p2o;
  logic [DW-1:0] p1d, p2d;

  // Advance the model by one clock edge using the inputs sampled at that edge
  task automatic model_step();
    int   g;
    int   free;
    ent_t e;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      movf = '0; mptr = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      e_rsp_valid = '0; e_rsp_data = '0; p1v = 0; p2v = 0;
      return;
    end
    e_rsp_valid = '0;
    if (p2v) begin
      e_rsp_valid[p2o] = 1'b1;
      e_rsp_data[p2o*DW +: DW] = p2d;
    end
    p2v = p1v; p2o = p1o; p2d = p1d; p1v = 0;
    g = -1;
    for (int k = 0; k < N; k++) begin
      automatic int j = (mptr + k) % N;
      if (g < 0 && mq[j].size() > 0) g = j;
    end
    e_en = 0; e_we = 0;
    if (g >= 0) begin
      e = mq[g].pop_front();
      e_en = 1; e_we = e.we; e_addr = e.addr; e_wdata = e.data;
      if (e.we) ref_mem[e.addr] = e.data;
      else begin p1v = 1; p1o = g; p1d = ref_mem[e.addr]; end
      mptr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      free = QD - mq[i].size();
      if (rd_req[i]) begin
        if (free > 0) begin
          e.we = 0; e.addr = rd_addr[i*AW +: AW]; e.data = '0;
          mq[i].push_back(e); free--;
        end else movf[i] = 1'b1;
      end
      if (wr_req[i]) begin
        if (free > 0) begin
          e.we = 1; e.addr = wr_addr[i*AW +: AW]; e.data = wr_data[i*DW +: DW];
          mq[i].push_back(e); free--;
        end else movf[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_req[i] = 1'b1; rd_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req[i] = 1'b1; wr_addr[i*AW +: AW] = a; wr_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1'b1; tick();
    rd_req = '1;                       // ignored while in reset
    tick(); rst = 1'b0; idle_inputs();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata, q_full, ovf, busy} !== '0)
        $display("FAIL reset_idle c%0d: rsp_valid=%b mem_en=%b mem_addr=%h q_full=%b ovf=%b busy=%b, required all 0",
                 c, rsp_valid, mem_en, mem_addr, q_full, ovf, busy);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_single_read();
    do_reset();
    set_rd(1, 10'd5); tick(); idle_inputs();          // cycle 0
    n_checks++;
    if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    tick();                                            // cycle 1
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd5})
      $display("FAIL single_bus: en=%b we=%b addr=%0d want en=1 we=0 addr=5", mem_en, mem_we, mem_addr);
    else n_pass++;
    tick();                                            // cycle 2
    n_checks++;
    if (rsp_valid !== 4'b0000) $display("FAIL single_early: rsp_valid=%b want 0000", rsp_valid);
    else n_pass++;
    tick();                                            // cycle 3
    n_checks++;
    if (rsp_valid !== 4'b0010 || rsp_data[1*DW +: DW] !== 32'hA5A5_0005)
      $display("FAIL single_rsp: rsp_valid=%b data=%h want 0010 / a5a50005", rsp_valid, rsp_data[1*DW +: DW]);
    else n_pass++;
    tick();
    n_checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0)
      $display("FAIL single_after: rsp_valid=%b busy=%b want 0000 / 0", rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < N; i++) set_rd(i, AW'(i));
    tick(); idle_inputs();
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) begin
        n_checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, AW'(c - 1)})
          $display("FAIL contention_gnt c%0d: en=%b we=%b addr=%0d want 1/0/%0d", c, mem_en, mem_we, mem_addr, c - 1);
        else n_pass++;
      end
      if (c >= 3) begin
        n_checks++;
        if (rsp_valid !== N'(1 << (c - 3)) || rsp_data[(c-3)*DW +: DW] !== (32'hA5A5_0000 | (c - 3)))
          $display("FAIL contention_rsp c%0d: rsp_valid=%b data=%h want %b / %h", c, rsp_valid,
                   rsp_data[(c-3)*DW +: DW], N'(1 << (c - 3)), 32'hA5A5_0000 | (c - 3));
        else n_pass++;
      end
    end
    // Pointer back at 0: LSU0 must win over LSU3
    set_rd(0, 10'd10); set_rd(3, 10'd13); tick(); idle_inputs();
    tick();
    n_checks++;
    if (mem_addr !== 10'd10) $display("FAIL contention_ptr0: addr=%0d want 10", mem_addr); else n_pass++;
    tick();
    n_checks++;
    if (mem_addr !== 10'd13) $display("FAIL contention_ptr1: addr=%0d want 13", mem_addr); else n_pass++;
    repeat (4) tick();
  endtask

  task automatic test_rd_wr_same();
    bit seen;
    do_reset();
    sram[7] = 32'hBEEF; ref_mem[7] = 32'hBEEF;
    set_rd(2, 10'd7); set_wr(2, 10'd7, 32'h1234); tick(); idle_inputs();
    tick();
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd7})
      $display("FAIL rw_read_gnt: en=%b we=%b addr=%0d want 1/0/7", mem_en, mem_we, mem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'd7, 32'h1234})
      $display("FAIL rw_write_gnt: en=%b we=%b addr=%0d wdata=%h want 1/1/7/1234", mem_en, mem_we, mem_addr, mem_wdata);
    else n_pass++;
    tick();
    n_checks++;
    if (rsp_valid !== 4'b0100 || rsp_data[2*DW +: DW] !== 32'hBEEF)
      $display("FAIL rw_old_data: rsp_valid=%b data=%h want 0100 / beef", rsp_valid, rsp_data[2*DW +: DW]);
    else n_pass++;
    set_rd(2, 10'd7); tick(); idle_inputs();
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (rsp_valid[2]) seen = 1;
    end
    n_checks++;
    if (!seen || rsp_data[2*DW +: DW] !== 32'h1234)
      $display("FAIL rw_new_data: seen=%b data=%h want 1 / 1234", seen, rsp_data[2*DW +: DW]);
    else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_overflow();
    int acc;
    do_reset();
    set_rd(0, 10'd20); set_wr(0, 10'd21, 32'h55);
    tick();                                            // cycle 0
    n_checks++;
    if (q_full !== 4'b0001) $display("FAIL ovf_full0: q_full=%b want 0001", q_full); else n_pass++;
    tick(); idle_inputs();                             // cycle 1
    n_checks++;
    if (q_full !== 4'b0001) $display("FAIL ovf_full1: q_full=%b want 0001", q_full); else n_pass++;
    acc = int'(mem_en);
    for (int c = 2; c < 10; c++) begin
      tick();
      acc += int'(mem_en);
      n_checks++;
      if (ovf !== 4'b0001) $display("FAIL ovf_sticky c%0d: ovf=%b want 0001", c, ovf); else n_pass++;
    end
    n_checks++;
    if (acc !== 3) $display("FAIL ovf_accesses: got %0d want 3", acc); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    bit seen;
    do_reset();
    set_rd(3, 10'd9); tick(); idle_inputs();           // cycle 0
    tick();                                            // cycle 1
    n_checks++;
    if ({mem_en, mem_addr} !== {1'b1, 10'd9})
      $display("FAIL mid_gnt: en=%b addr=%0d want 1/9", mem_en, mem_addr);
    else n_pass++;
    rst = 1'b1; tick(); rst = 1'b0;                    // cycle 2
    for (int c = 2; c <= 3; c++) begin
      n_checks++;
      if ({rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata, q_full, ovf, busy} !== '0)
        $display("FAIL mid_zero c%0d: rsp_valid=%b mem_en=%b mem_addr=%h busy=%b, required all 0",
                 c, rsp_valid, mem_en, mem_addr, busy);
      else n_pass++;
      tick();
    end
    seen = 0;
    repeat (5) begin
      if (rsp_valid != '0) seen = 1;
      tick();
    end
    n_checks++;
    if (seen) $display("FAIL mid_no_rsp: rsp_valid pulsed after reset, want none"); else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] e_full;
    bit           e_busy;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c < 560) begin
        rst = ($urandom_range(199) == 0);
        for (int i = 0; i < N; i++) begin
          rd_req[i] = ($urandom_range(99) < 15);
          wr_req[i] = ($urandom_range(99) < 10);
          rd_addr[i*AW +: AW] = AW'($urandom_range(15));
          wr_addr[i*AW +: AW] = AW'($urandom_range(15));
          wr_data[i*DW +: DW] = $urandom;
        end
      end else begin
        rst = 1'b0; idle_inputs();
      end
      tick();
      e_busy = p1v || p2v;
      for (int i = 0; i < N; i++) begin
        e_full[i] = (mq[i].size() == QD);
        if (mq[i].size() > 0) e_busy = 1;
      end
      n_checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_en, e_we, e_addr, e_wdata})
        $display("FAIL rand_bus c%0d: en=%b we=%b addr=%h wdata=%h want %b %b %h %h",
                 c, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wdata);
      else n_pass++;
      n_checks++;
      if (rsp_valid !== e_rsp_valid || rsp_data !== e_rsp_data)
        $display("FAIL rand_rsp c%0d: valid=%b data=%h want %b %h", c, rsp_valid, rsp_data, e_rsp_valid, e_rsp_data);
      else n_pass++;
      n_checks++;
      if ({q_full, ovf, busy} !== {e_full, movf, e_busy})
        $display("FAIL rand_status c%0d: q_full=%b ovf=%b busy=%b want %b %b %b",
                 c, q_full, ovf, busy, e_full, movf, e_busy);
      else n_pass++;
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      sram[a]    = 32'hA5A5_0000 | a;
      ref_mem[a] = 32'hA5A5_0000 | a;
    end
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_rd_wr_same();
    test_overflow();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
